// File: rtl/fifo_drain.sv
// Read-side burst consumer for the async FIFO: pulls burst_len words with 1-cycle
// read latency and delivers them on a valid/ready stream through a 2-entry skid buffer.
module fifo_drain #(
   parameter int unsigned datasize = 32,
   parameter int unsigned lenbits  = 8
) (
   input  logic                clk_out,
   input  logic                rst,
   input  logic                start,
   input  logic [lenbits-1:0]  burst_len,
   input  logic                empty,
   input  logic [datasize-1:0] dataOut,
   input  logic                sync_flush,
   output logic                remove,
   output logic [datasize-1:0] m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic [lenbits-1:0]  count
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t              state;
   logic [lenbits-1:0]  len;
   logic [lenbits-1:0]  issued;
   logic [datasize-1:0] skid [2];
   logic                rd_ptr;
   logic                wr_ptr;
   logic [1:0]          buf_cnt;
   logic                inflight;

   logic                xfer;
   logic [2:0]          occ;
   logic [1:0]          buf_cnt_nxt;
   logic [lenbits-1:0]  count_nxt;
   logic                drain_done;

   assign m_valid = (buf_cnt != 2'd0);
   assign m_data  = skid[rd_ptr];
   assign xfer    = m_valid && m_ready;

   // A word may be requested only if it will have a free slot when it lands.
   always_comb begin
      remove      = 1'b0;
      occ         = 3'(buf_cnt) + 3'(inflight);
      buf_cnt_nxt = buf_cnt + 2'(inflight) - 2'(xfer);
      count_nxt   = count + lenbits'(xfer);
      drain_done  = !inflight && (buf_cnt_nxt == 2'd0) && (count_nxt == len);
      if (state == S_READ && !sync_flush && !empty && (issued < len) &&
          (occ < (3'd2 + 3'(xfer))))
         remove = 1'b1;
   end

   always_ff @(posedge clk_out) begin
      if (rst) begin
         state    <= S_IDLE;
         len      <= '0;
         issued   <= '0;
         skid[0]  <= '0;
         skid[1]  <= '0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         buf_cnt  <= 2'd0;
         inflight <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
         count    <= '0;
      end else begin
         done     <= 1'b0;
         aborted  <= 1'b0;
         inflight <= remove;
         buf_cnt  <= buf_cnt_nxt;
         count    <= count_nxt;
         if (inflight) begin
            skid[wr_ptr] <= dataOut;
            wr_ptr       <= ~wr_ptr;
         end
         if (xfer)
            rd_ptr <= ~rd_ptr;
         if (remove)
            issued <= issued + lenbits'(1);
         // Flush discards buffered and in-flight words in every state.
         if (sync_flush) begin
            buf_cnt  <= 2'd0;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (start && !sync_flush) begin
                  len    <= burst_len;
                  issued <= '0;
                  count  <= '0;
                  busy   <= 1'b1;
                  if (burst_len == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (sync_flush) begin
                  state   <= S_IDLE;
                  busy    <= 1'b0;
                  aborted <= 1'b1;
               end else if (remove && ((issued + lenbits'(1)) == len)) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (sync_flush) begin
                  state   <= S_IDLE;
                  busy    <= 1'b0;
                  aborted <= 1'b1;
               end else if (drain_done) begin
                  // Leaves on the edge of the final transfer so done follows it directly.
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: a behavioural FIFO with 1-cycle read latency,
// a stream scoreboard, and hand-computed per-cycle output histories.
module tb_fifo_drain;

   logic        clk_out = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  burst_len = '0;
   logic        empty;
   logic [31:0] dataOut = '0;
   logic        sync_flush = 1'b0;
   logic        remove;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [7:0]  count;

   int checks = 0;
   int errors = 0;

   fifo_drain #(.datasize(32), .lenbits(8)) dut (
      .clk_out(clk_out), .rst(rst), .start(start), .burst_len(burst_len),
      .empty(empty), .dataOut(dataOut), .sync_flush(sync_flush),
      .remove(remove), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .done(done), .aborted(aborted), .count(count)
   );

   initial forever #5 clk_out = ~clk_out;

   // Behavioural FIFO: data appears one cycle after the remove cycle.
   logic [31:0] mem [256];
   int wp = 0;
   int rp = 0;
   assign empty = (wp == rp);

   always @(posedge clk_out) begin
      if (remove && !empty) begin
         dataOut <= mem[rp[7:0]];
         rp      <= rp + 1;
      end
   end

   logic [31:0] expq [$];
   int          outst = 0;
   bit          stalled = 1'b0;
   logic [31:0] held = '0;
   int          done_cnt = 0;
   logic [15:0] rem_h, val_h, done_h, busy_h, abort_h;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      mem[wp[7:0]] = w;
      wp = wp + 1;
   endtask

   // Scoreboard step, evaluated mid-cycle on settled signals.
   task automatic monitor_step();
      if (m_valid && m_ready) begin
         chk("xfer_expected", 64'(expq.size() != 0), 64'd1);
         if (expq.size() != 0) chk("order", 64'(m_data), 64'(expq.pop_front()));
         outst--;
      end
      if (stalled && m_valid) chk("stable", 64'(m_data), 64'(held));
      stalled = m_valid && !m_ready;
      held    = m_data;
      if (remove) begin
         chk("rem_empty", 64'(empty), 64'd0);
         expq.push_back(mem[rp[7:0]]);
         outst++;
         chk("occupancy", 64'(outst <= 2), 64'd1);
      end
      if (done) done_cnt++;
      if (rst || sync_flush) begin
         expq.delete();
         outst   = 0;
         stalled = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge clk_out);
      monitor_step();
      @(posedge clk_out);
      #2;
   endtask

   task automatic start_burst(input logic [7:0] n);
      start     = 1'b1;
      burst_len = n;
      tick();
      start     = 1'b0;
   endtask

   // Patterns and histories read left-to-right as cycle 1..n.
   task automatic run_cycles(input int n, input logic [15:0] rdy, input logic [15:0] fl);
      rem_h = '0; val_h = '0; done_h = '0; busy_h = '0; abort_h = '0;
      for (int i = 1; i <= n; i++) begin
         m_ready    = rdy[n-i];
         sync_flush = fl[n-i];
         #1;
         rem_h   = {rem_h[14:0], remove};
         val_h   = {val_h[14:0], m_valid};
         done_h  = {done_h[14:0], done};
         busy_h  = {busy_h[14:0], busy};
         abort_h = {abort_h[14:0], aborted};
         tick();
      end
      sync_flush = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      bit seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         if (done) seen = 1'b1;
         else tick();
      end
      chk("done_timeout", 64'(seen), 64'd1);
   endtask

   initial begin
      int d0;
      tick();
      tick();
      chk("rst_remove", 64'(remove), 64'd0);
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_aborted", 64'(aborted), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_data", 64'(m_data), 64'd0);
      rst = 1'b0;
      tick();

      // 1: full-rate burst of 4
      for (int i = 0; i < 4; i++) push(32'h11 + 32'(i));
      m_ready = 1'b1;
      start_burst(8'd4);
      run_cycles(8, 16'hFFFF, 16'h0);
      chk("t1_remove", 64'(rem_h), 64'(8'b1111_0000));
      chk("t1_valid", 64'(val_h), 64'(8'b0011_1100));
      chk("t1_done", 64'(done_h), 64'(8'b0000_0010));
      chk("t1_busy", 64'(busy_h), 64'(8'b1111_1110));
      chk("t1_count", 64'(count), 64'd4);
      chk("t1_drained", 64'(expq.size()), 64'd0);

      // 2: backpressure 1,0,0 repeating
      for (int i = 0; i < 6; i++) push(32'h21 + 32'(i));
      d0 = done_cnt;
      start_burst(8'd6);
      run_cycles(16, 16'b1001_0010_0100_1001, 16'h0);
      m_ready = 1'b1;
      wait_done(40);
      chk("t2_count", 64'(count), 64'd6);
      tick();
      chk("t2_done_once", 64'(done_cnt - d0), 64'd1);
      chk("t2_drained", 64'(expq.size()), 64'd0);
      chk("t2_busy", 64'(busy), 64'd0);

      // 3: FIFO runs dry mid-burst
      push(32'h31);
      push(32'h32);
      d0 = done_cnt;
      start_burst(8'd5);
      run_cycles(12, 16'hFFFF, 16'h0);
      chk("t3_remove", 64'(rem_h), 64'(12'b1100_0000_0000));
      chk("t3_valid", 64'(val_h), 64'(12'b0011_0000_0000));
      chk("t3_busy", 64'(busy_h), 64'(12'hFFF));
      for (int i = 0; i < 3; i++) push(32'h33 + 32'(i));
      wait_done(30);
      chk("t3_count", 64'(count), 64'd5);
      tick();
      chk("t3_done_once", 64'(done_cnt - d0), 64'd1);
      chk("t3_drained", 64'(expq.size()), 64'd0);

      // 4: flush after 3 transfers, then a normal burst of 2
      for (int i = 0; i < 8; i++) push(32'h41 + 32'(i));
      start_burst(8'd8);
      run_cycles(8, 16'b1111_1000, 16'b0000_0100);
      chk("t4_remove", 64'(rem_h), 64'(8'b1111_1000));
      chk("t4_valid", 64'(val_h), 64'(8'b0011_1100));
      chk("t4_aborted", 64'(abort_h), 64'(8'b0000_0010));
      chk("t4_busy", 64'(busy_h), 64'(8'b1111_1100));
      chk("t4_no_done", 64'(done_h), 64'd0);
      chk("t4_count", 64'(count), 64'd3);
      m_ready = 1'b1;
      start_burst(8'd2);
      run_cycles(7, 16'hFFFF, 16'h0);
      chk("t4b_remove", 64'(rem_h), 64'(7'b110_0000));
      chk("t4b_valid", 64'(val_h), 64'(7'b001_1000));
      chk("t4b_done", 64'(done_h), 64'(7'b000_0100));
      chk("t4b_busy", 64'(busy_h), 64'(7'b111_1100));
      chk("t4b_count", 64'(count), 64'd2);
      chk("t4b_drained", 64'(expq.size()), 64'd0);

      // 5: zero-length burst
      start_burst(8'd0);
      run_cycles(3, 16'hFFFF, 16'h0);
      chk("t5_done", 64'(done_h), 64'(3'b100));
      chk("t5_busy", 64'(busy_h), 64'(3'b100));
      chk("t5_remove", 64'(rem_h), 64'd0);
      chk("t5_count", 64'(count), 64'd0);

      // start together with flush in IDLE: flush wins
      start      = 1'b1;
      sync_flush = 1'b1;
      burst_len  = 8'd3;
      tick();
      start      = 1'b0;
      sync_flush = 1'b0;
      chk("sf_busy", 64'(busy), 64'd0);
      chk("sf_aborted", 64'(aborted), 64'd0);

      // 6: reset during DRAIN with one word buffered (leftover 0x48)
      m_ready = 1'b0;
      start_burst(8'd1);
      #1;
      chk("t6_remove", 64'(remove), 64'd1);
      tick();
      tick();
      chk("t6_valid", 64'(m_valid), 64'd1);
      chk("t6_data", 64'(m_data), 64'h48);
      rst       = 1'b1;
      start     = 1'b1;
      burst_len = 8'd0;
      tick();
      rst = 1'b0;
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_valid0", 64'(m_valid), 64'd0);
      chk("t6_done", 64'(done), 64'd0);
      chk("t6_aborted", 64'(aborted), 64'd0);
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_data0", 64'(m_data), 64'd0);
      tick();
      start = 1'b0;
      chk("t6_accept_done", 64'(done), 64'd1);
      chk("t6_accept_busy", 64'(busy), 64'd1);
      tick();
      chk("t6_idle", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
- Read-side consumer for the asynchronous FIFO, living entirely in the clk_out domain.
- On a start request it pulls exactly burst_len words from the FIFO using remove/empty/dataOut, honouring the FIFO's 1-cycle read latency.
- Delivered words go out on a valid/ready stream through a 2-entry skid buffer, so the FIFO can be drained at full rate under downstream backpressure.
- Reports completion with done; a synchronized flush aborts the burst cleanly.

Parameters:
- datasize, 32, width of the FIFO word and of the stream data.
- lenbits, 8, width of burst_len and count; maximum burst is 2^lenbits-1 words.

Ports:
- clk_out  in  1  read-domain clock; sole clock of the block.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a burst; sampled only in IDLE.
- burst_len  in  lenbits  number of words in the burst; captured on an accepted start.
- empty  in  1  FIFO empty flag, read domain.
- dataOut  in  datasize  FIFO read data; valid exactly 1 cycle after a remove cycle.
- sync_flush  in  1  flush, already synchronized to clk_out.
- remove  out  1  FIFO read strobe; one word per high cycle.
- m_data  out  datasize  stream data = head of the skid buffer.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready; transfer occurs when m_valid && m_ready.
- busy  out  1  high in READ, DRAIN and DONE.
- done  out  1  1-cycle pulse after the last word of a burst transfers.
- aborted  out  1  1-cycle pulse when sync_flush kills an active burst.
- count  out  lenbits  words transferred on the stream in the current or last burst.

Behaviour:
- Reset (rst high at a clk_out edge): state=IDLE. remove, m_valid, busy, done and aborted are 0. count=0, m_data=0. Skid buffer and in-flight flag are cleared.
- State IDLE:
  - start=1 with burst_len!=0: latch len, clear issued and count, go to READ.
  - start=1 with burst_len=0: go to DONE; no remove is issued and count becomes 0.
- State READ:
  - remove = !empty && (issued<len) && (buf_cnt + inflight - xfer < 2), where xfer = m_valid && m_ready and inflight = remove registered 1 cycle.
  - remove is combinational from registered state, empty and m_ready only.
  - When issued reaches len, go to DRAIN on the same edge as the final remove.
- Capture: in the cycle after remove, dataOut is written into the skid buffer. Capture and stream transfer may happen in the same cycle; buf_cnt is then unchanged.
- Ordering: buffer entries leave strictly in FIFO order. m_data must be stable while m_valid && !m_ready.
- Occupancy: buf_cnt + inflight never exceeds 2, so no word is ever dropped.
- Throughput: with m_ready held high and the FIFO non-empty, remove is high every cycle and m_valid is high every cycle starting from the 2nd cycle after the first remove.
- count increments on every xfer.
- State DRAIN: remove=0. When inflight=0, buf_cnt=0 and count==len, go to DONE.
- State DONE: done=1 for exactly this one cycle, then go to IDLE. busy=1 in DONE. A start during DONE is ignored.
- sync_flush=1 in READ or DRAIN:
  - Next state IDLE; skid buffer and inflight are cleared; m_valid drops the following cycle.
  - aborted pulses 1 cycle; done is not asserted; count holds its last value.
  - remove is forced to 0 in the flush cycle.
- sync_flush in IDLE or DONE: the buffer is cleared; no aborted pulse. If it coincides with DONE, done still pulses.
- Simultaneous start and sync_flush in IDLE: flush wins and start is ignored.
- empty rising mid-burst: remove stalls and resumes when empty falls; there is no timeout.
- rst mid-burst: immediate return to the reset state; neither done nor aborted pulses.

Test Plan:
1. FIFO preloaded with 0x11..0x14, burst_len=4, m_ready=1 -> remove high 4 consecutive cycles; m_data 0x11,0x12,0x13,0x14 on consecutive cycles; done pulses 1 cycle after the last transfer; count=4; busy low again afterwards.
2. burst_len=6, m_ready toggling 1,0,0,1,... with FIFO full -> no word lost or duplicated; buf_cnt+inflight<=2 at all times; m_data stable while stalled; order preserved; count=6.
3. burst_len=5, FIFO holds 2 words and 3 more arrive 10 cycles later -> remove stalls while empty=1; all 5 words delivered in order; done pulses once.
4. burst_len=8, sync_flush asserted after 3 transfers -> aborted pulses; count=3; m_valid low next cycle; state IDLE; a new start with burst_len=2 then completes normally.
5. burst_len=0 start -> zero remove cycles; done pulses on the next cycle; count=0.
6. rst asserted during DRAIN with 1 word buffered -> next cycle all outputs 0, no done and no aborted; start ignored in the rst cycle, accepted the cycle after.
